// File: rtl/multiplier_seq_if.sv
// ---------------------------------------------------------------------------
// multiplier_seq_if
// Operand/result bundle for the sequential shift-add multiplier.
//   multiplicand  WIDTH     operand A, sampled on the acceptance edge
//   multiplier    WIDTH     operand B, sampled on the acceptance edge
//   valid         1         start request
//   product       2*WIDTH   A*B, held until the next completion
//   vld           1         one-cycle pulse when product updates
//   busy          1         operation in flight
// master drives operands/valid; slave (the multiplier) drives the results.
// ---------------------------------------------------------------------------
interface multiplier_seq_if #(
   parameter int WIDTH = 64
) ();
   logic [WIDTH-1:0]   multiplicand;
   logic [WIDTH-1:0]   multiplier;
   logic               valid;
   logic [2*WIDTH-1:0] product;
   logic               vld;
   logic               busy;

   modport master (
      output multiplicand, multiplier, valid,
      input  product, vld, busy
   );

   modport slave (
      input  multiplicand, multiplier, valid,
      output product, vld, busy
   );
endinterface

// File: rtl/multiplier_seq.sv
// ---------------------------------------------------------------------------
// multiplier_seq
// Iterative unsigned shift-add multiplier, one multiplier bit per clock.
// Latency is fixed at WIDTH clocks from acceptance to the vld pulse,
// independent of operand values; throughput is one result per WIDTH+1 clocks.
// Ports:
//   clk   rising-edge clock
//   arst  asynchronous active-low reset (aborts any operation in flight)
//   bus   multiplier_seq_if.slave: multiplicand, multiplier, valid in;
//         product, vld, busy out
// ---------------------------------------------------------------------------
module multiplier_seq #(
   parameter int WIDTH = 64
) (
   input  logic            clk,
   input  logic            arst,
   multiplier_seq_if.slave bus
);
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t             state_reg, state_next;
   logic [2*WIDTH-1:0] acc_reg, acc_next;
   logic [2*WIDTH-1:0] opa_reg, opa_next;
   logic [2*WIDTH-1:0] product_reg, product_next;
   logic [2*WIDTH-1:0] addend;
   logic [WIDTH-1:0]   opb_reg, opb_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic               vld_reg, vld_next;
   logic               busy_reg, busy_next;

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         state_reg   <= IDLE;
         acc_reg     <= '0;
         opa_reg     <= '0;
         opb_reg     <= '0;
         cnt_reg     <= '0;
         product_reg <= '0;
         vld_reg     <= 1'b0;
         busy_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         acc_reg     <= acc_next;
         opa_reg     <= opa_next;
         opb_reg     <= opb_next;
         cnt_reg     <= cnt_next;
         product_reg <= product_next;
         vld_reg     <= vld_next;
         busy_reg    <= busy_next;
      end
   end

   // Rather than a variable shift (opA << cnt) tested against opB[cnt], the
   // partial product register is shifted left and the multiplier right by one
   // each step; the accumulated sums are identical and no barrel shifter is
   // needed. opA's upper half starts at zero and is shifted at most WIDTH-1
   // times, so nothing is lost off the top.
   always_comb begin
      state_next   = state_reg;
      acc_next     = acc_reg;
      opa_next     = opa_reg;
      opb_next     = opb_reg;
      cnt_next     = cnt_reg;
      product_next = product_reg;
      vld_next     = 1'b0;
      busy_next    = busy_reg;
      addend       = opb_reg[0] ? opa_reg : '0;

      case (state_reg)
         IDLE: begin
            if (bus.valid) begin
               opa_next   = {{WIDTH{1'b0}}, bus.multiplicand};
               opb_next   = bus.multiplier;
               acc_next   = '0;
               cnt_next   = '0;
               busy_next  = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            acc_next = acc_reg + addend;
            opa_next = opa_reg << 1;
            opb_next = opb_reg >> 1;
            // cnt may wrap to zero on the final step; the compare below
            // already used the pre-increment value.
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == CNT_LAST) begin
               product_next = acc_reg + addend;
               vld_next     = 1'b1;
               busy_next    = 1'b0;
               state_next   = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.product = product_reg;
   assign bus.vld     = vld_reg;
   assign bus.busy    = busy_reg;
endmodule

// File: tb/tb_multiplier_seq.sv
// ---------------------------------------------------------------------------
// tb_multiplier_seq
// Scoreboard bench for multiplier_seq: a 64-bit instance for directed cases
// and an 8-bit instance for randomized pairs. Issue tasks push the expected
// product (plain a*b) and the acceptance cycle; per-instance monitors pop
// and compare whenever vld is seen.
// ---------------------------------------------------------------------------
module tb_multiplier_seq;
   localparam int W  = 64;
   localparam int W8 = 8;

   logic clk  = 1'b0;
   logic arst = 1'b0;
   always #5 clk = ~clk;

   multiplier_seq_if #(.WIDTH(W))  bus64 ();
   multiplier_seq_if #(.WIDTH(W8)) bus8 ();

   multiplier_seq #(.WIDTH(W))  dut64 (.clk(clk), .arst(arst), .bus(bus64.slave));
   multiplier_seq #(.WIDTH(W8)) dut8  (.clk(clk), .arst(arst), .bus(bus8.slave));

   int     vectors     = 0;
   int     miscompares = 0;
   longint cyc         = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [127:0] exp64_q[$];
   longint       acc64_q[$];
   logic [15:0]  exp8_q[$];
   longint       acc8_q[$];
   int           busy64_cnt = 0, busy8_cnt = 0;
   int           issued64 = 0, seen64 = 0;
   logic [127:0] e64;
   longint       a64;
   logic [15:0]  e8;
   longint       a8;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic timeout_fail(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: got no response within bound, expected one", name);
   endtask

   // ---------------- monitors ----------------
   always @(negedge clk) begin
      if (!arst) begin
         busy64_cnt = 0;
      end else begin
         if (bus64.busy) busy64_cnt++;
         if (bus64.vld) begin
            seen64++;
            if (exp64_q.size() == 0) begin
               check("vld64_unexpected", 128'd1, 128'd0);
            end else begin
               e64 = exp64_q.pop_front();
               a64 = acc64_q.pop_front();
               check("product64", bus64.product, e64);
               check("latency64", 128'(cyc - a64), 128'd64);
               check("busy_cycles64", 128'(busy64_cnt), 128'd64);
               check("busy_at_vld64", 128'(bus64.busy), 128'd0);
            end
            busy64_cnt = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (!arst) begin
         busy8_cnt = 0;
      end else begin
         if (bus8.busy) busy8_cnt++;
         if (bus8.vld) begin
            if (exp8_q.size() == 0) begin
               check("vld8_unexpected", 128'd1, 128'd0);
            end else begin
               e8 = exp8_q.pop_front();
               a8 = acc8_q.pop_front();
               check("product8", 128'(bus8.product), 128'(e8));
               check("latency8", 128'(cyc - a8), 128'd8);
               check("busy_cycles8", 128'(busy8_cnt), 128'd8);
            end
            busy8_cnt = 0;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic issue64(input logic [63:0] a, input logic [63:0] b, input bit hold,
                          output longint acc_cyc);
      int n = 0;
      acc_cyc = -1;
      @(negedge clk);
      while (bus64.busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (bus64.busy) begin
         timeout_fail("issue64_wait");
         return;
      end
      bus64.multiplicand = a;
      bus64.multiplier   = b;
      bus64.valid        = 1'b1;
      @(posedge clk);
      #1;
      exp64_q.push_back({64'd0, a} * {64'd0, b});
      acc64_q.push_back(cyc);
      acc_cyc = cyc;
      issued64++;
      // Operands may change freely once accepted.
      bus64.multiplicand = {$urandom, $urandom};
      bus64.multiplier   = {$urandom, $urandom};
      if (!hold) bus64.valid = 1'b0;
   endtask

   task automatic issue8(input logic [7:0] a, input logic [7:0] b, input bit hold);
      int n = 0;
      @(negedge clk);
      while (bus8.busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (bus8.busy) begin
         timeout_fail("issue8_wait");
         return;
      end
      bus8.multiplicand = a;
      bus8.multiplier   = b;
      bus8.valid        = 1'b1;
      @(posedge clk);
      #1;
      exp8_q.push_back({8'd0, a} * {8'd0, b});
      acc8_q.push_back(cyc);
      bus8.multiplicand = 8'($urandom);
      bus8.multiplier   = 8'($urandom);
      if (!hold) bus8.valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp64_q.size() != 0 || exp8_q.size() != 0) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (exp64_q.size() != 0 || exp8_q.size() != 0) begin
         timeout_fail("drain");
         exp64_q.delete(); acc64_q.delete();
         exp8_q.delete();  acc8_q.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      longint t, t_prev;
      bus64.multiplicand = '0; bus64.multiplier = '0; bus64.valid = 1'b0;
      bus8.multiplicand  = '0; bus8.multiplier  = '0; bus8.valid  = 1'b0;

      repeat (3) @(negedge clk);
      check("reset_product64", bus64.product, 128'd0);
      check("reset_vld64", 128'(bus64.vld), 128'd0);
      check("reset_busy64", 128'(bus64.busy), 128'd0);
      check("reset_product8", 128'(bus8.product), 128'd0);
      arst = 1'b1;
      repeat (2) @(negedge clk);

      // 3 * 5, busy right after acceptance
      issue64(64'd3, 64'd5, 1'b0, t);
      check("busy_after_accept", 128'(bus64.busy), 128'd1);
      check("vld_after_accept", 128'(bus64.vld), 128'd0);
      drain();
      check("product_held", bus64.product, 128'd15);

      // all-ones corner
      issue64('1, '1, 1'b0, t);
      drain();
      check("allones_literal", bus64.product, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);

      // zero and single-bit operands
      issue64(64'd0, 64'h1234, 1'b0, t);
      drain();
      issue64(64'd1, 64'h8000_0000_0000_0000, 1'b0, t);
      drain();

      // valid pulses while busy must be ignored
      issue64(64'hDEAD_BEEF_0123_4567, 64'h0F0F_F0F0_1357_9BDF, 1'b0, t);
      repeat (9) @(negedge clk);
      bus64.multiplicand = 64'd7; bus64.multiplier = 64'd9; bus64.valid = 1'b1;
      @(negedge clk);
      bus64.valid = 1'b0;
      repeat (19) @(negedge clk);
      bus64.multiplicand = 64'd11; bus64.multiplier = 64'd13; bus64.valid = 1'b1;
      @(negedge clk);
      bus64.valid = 1'b0;
      drain();
      repeat (80) @(negedge clk);

      // valid held high: back-to-back, one acceptance every 65 clocks
      issue64({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, t_prev);
      for (int i = 0; i < 4; i++) begin
         issue64({$urandom, $urandom}, {$urandom, $urandom}, (i != 3), t);
         check("b2b_interval", 128'(t - t_prev), 128'd65);
         t_prev = t;
      end
      drain();

      // reset mid-operation aborts with no vld
      issue64(64'h1234_5678, 64'h9ABC_DEF0, 1'b0, t);
      repeat (20) @(negedge clk);
      arst = 1'b0;
      #1;
      check("abort_product", bus64.product, 128'd0);
      check("abort_busy", 128'(bus64.busy), 128'd0);
      check("abort_vld", 128'(bus64.vld), 128'd0);
      if (exp64_q.size() != 0) begin
         void'(exp64_q.pop_front());
         void'(acc64_q.pop_front());
         issued64--;
      end
      repeat (2) @(negedge clk);
      arst = 1'b1;
      repeat (100) @(negedge clk);
      issue64(64'd123456789, 64'd987654321, 1'b0, t);
      drain();

      // random 64-bit pairs
      for (int i = 0; i < 20; i++)
         issue64({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), t);
      bus64.valid = 1'b0;
      drain();

      // 8-bit instance: 1000 random pairs, random back-to-back
      for (int i = 0; i < 1000; i++)
         issue8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      bus8.valid = 1'b0;
      drain();

      check("vld64_count", 128'(seen64), 128'(issued64));
      check("queues_empty", 128'(exp64_q.size() + exp8_q.size()), 128'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
